fft_frame_scheduler: RTL and testbench

FFT_FRAME_SCHEDULER -- requirements
Module: fft_frame_scheduler

---
 rtl/fft_frame_scheduler_pkg.sv | 21 ++
 rtl/fft_frame_scheduler_bank_ram.sv | 40 ++++
 rtl/fft_frame_scheduler.sv | 179 +++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_scheduler_pkg.sv
// Shared definitions for the FFT frame scheduler: parameter defaults,
// address-width helper and the scheduler FSM state encodings.
package fft_frame_scheduler_pkg;

   localparam int unsigned N_SAMPLES_DEFAULT   = 64;
   localparam int unsigned SAMPLE_W_DEFAULT    = 16;
   localparam int unsigned TIMEOUT_CYC_DEFAULT = 4096;

   function automatic int unsigned addr_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned ADDR_W_DEFAULT = addr_width(N_SAMPLES_DEFAULT);

   // Scheduler states; encodings kept stable for legacy debug tooling.
   localparam logic [1:0] ST_FILL      = 2'd0;
   localparam logic [1:0] ST_LAUNCH    = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;
   localparam logic [1:0] ST_COMMIT    = 2'd3;

endpackage

// File: rtl/fft_frame_scheduler_bank_ram.sv
// Dual-bank sample store: one write port, one registered read port.
// Storage is not reset; only the read data register is.
module frame_bank_ram
   import fft_frame_scheduler_pkg::*;
#(
   parameter int unsigned N_SAMPLES = N_SAMPLES_DEFAULT,
   parameter int unsigned SAMPLE_W  = SAMPLE_W_DEFAULT,
   parameter int unsigned ADDR_W    = addr_width(N_SAMPLES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en_i,
   input  logic                wr_bank_i,
   input  logic [ADDR_W-1:0]   wr_addr_i,
   input  logic [SAMPLE_W-1:0] wr_data_i,
   input  logic                rd_bank_i,
   input  logic [ADDR_W-1:0]   rd_addr_i,
   output logic [SAMPLE_W-1:0] rd_data_o
);

   logic [SAMPLE_W-1:0] mem_q [2*N_SAMPLES];
   logic [SAMPLE_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_frame_scheduler.sv
// FFT frame scheduler: ping-pong sample capture, FFT launch and display commit.
// Define FFT_TIMEOUT_EN to enable the fft_start -> fft_done watchdog.
module fft_frame_scheduler
   import fft_frame_scheduler_pkg::*;
#(
   parameter int unsigned N_SAMPLES   = N_SAMPLES_DEFAULT,
   parameter int unsigned SAMPLE_W    = SAMPLE_W_DEFAULT,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             sample_valid,
   input  logic [SAMPLE_W-1:0]              sample_data,
   input  logic                             fft_ready,
   output logic                             fft_start,
   input  logic [addr_width(N_SAMPLES)-1:0] fft_rd_addr,
   output logic [SAMPLE_W-1:0]              fft_rd_data,
   input  logic                             fft_done,
   output logic                             disp_bank,
   output logic [7:0]                       frame_count,
   output logic                             overrun,
   output logic                             fft_error
);

   localparam int unsigned   AW       = addr_width(N_SAMPLES);
   localparam logic [AW-1:0] LAST_IDX = AW'(N_SAMPLES - 1);

   if (N_SAMPLES < 8 || N_SAMPLES > 256 || (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_bad_n
      $error("N_SAMPLES must be a power of two between 8 and 256");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_tmo
      $error("TIMEOUT_CYC must be at least 1");
   end

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] wr_idx_q, wr_idx_d;
   logic          cap_bank_q, cap_bank_d;
   logic          full_q, full_d;
   logic          start_q, start_d;
   logic          disp_q, disp_d;
   logic [7:0]    count_q, count_d;
   logic          overrun_q, overrun_d;
   logic          wr_en;
   logic          last_wr;
   logic          swap;
   logic          timeout;

   // Capture side: a full bank outside FILL parks wr_idx at the last index
   // until FILL swaps banks; samples arriving meanwhile are dropped.
   always_comb begin
      wr_en   = sample_valid && !full_q;
      last_wr = wr_en && (wr_idx_q == LAST_IDX);
      swap    = (state_q == ST_FILL) && (full_q || last_wr);

      wr_idx_d   = wr_idx_q;
      full_d     = full_q;
      cap_bank_d = cap_bank_q;
      overrun_d  = overrun_q || (sample_valid && full_q);

      if (swap) begin
         wr_idx_d   = '0;
         full_d     = 1'b0;
         cap_bank_d = ~cap_bank_q;
      end else if (last_wr) begin
         full_d = 1'b1;
      end else if (wr_en) begin
         wr_idx_d = wr_idx_q + 1'b1;
      end
   end

   // Commit results are registered on entry to COMMIT so they are visible
   // during the COMMIT cycle itself.
   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      disp_d  = disp_q;
      count_d = count_q;
      case (state_q)
         ST_FILL: begin
            if (swap) state_d = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            if (fft_ready) begin
               start_d = 1'b1;
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (fft_done) begin
               state_d = ST_COMMIT;
               disp_d  = ~disp_q;
               count_d = count_q + 8'd1;
            end else if (timeout) begin
               state_d = ST_FILL;
            end
         end
         ST_COMMIT: state_d = ST_FILL;
         default:   state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_FILL;
         wr_idx_q   <= '0;
         cap_bank_q <= 1'b0;
         full_q     <= 1'b0;
         start_q    <= 1'b0;
         disp_q     <= 1'b0;
         count_q    <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_idx_q   <= wr_idx_d;
         cap_bank_q <= cap_bank_d;
         full_q     <= full_d;
         start_q    <= start_d;
         disp_q     <= disp_d;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
      end
   end

`ifdef FFT_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] tmo_q, tmo_d;
   logic          error_q, error_d;

   // Counter is zero in the fft_start cycle; expiry lands TIMEOUT_CYC cycles later.
   always_comb begin
      tmo_d = tmo_q;
      if (start_d) begin
         tmo_d = '0;
      end else if (state_q == ST_WAIT_DONE) begin
         tmo_d = tmo_q + 1'b1;
      end
      timeout = (state_q == ST_WAIT_DONE) && !fft_done && (tmo_q == TW'(TIMEOUT_CYC - 1));
      error_d = error_q || timeout;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_q   <= '0;
         error_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         error_q <= error_d;
      end
   end

   assign fft_error = error_q;
`else
   assign timeout   = 1'b0;
   assign fft_error = 1'b0;
`endif

   frame_bank_ram #(
      .N_SAMPLES (N_SAMPLES),
      .SAMPLE_W  (SAMPLE_W),
      .ADDR_W    (AW)
   ) u_ram (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en),
      .wr_bank_i (cap_bank_q),
      .wr_addr_i (wr_idx_q),
      .wr_data_i (sample_data),
      .rd_bank_i (~cap_bank_q),
      .rd_addr_i (fft_rd_addr),
      .rd_data_o (fft_rd_data)
   );

   assign fft_start   = start_q;
   assign disp_bank   = disp_q;
   assign frame_count = count_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomized bench for fft_frame_scheduler against a frame-level reference model.
// Honors FFT_TIMEOUT_EN the same way the design does.
module tb_fft_frame_scheduler;

   localparam int unsigned N   = 64;
   localparam int unsigned W   = 16;
   localparam int unsigned AW  = 6;
   localparam int unsigned TMO = 4096;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          sample_valid = 1'b0;
   logic [W-1:0]  sample_data = '0;
   logic          fft_ready = 1'b0;
   logic          fft_start;
   logic [AW-1:0] fft_rd_addr = '0;
   logic [W-1:0]  fft_rd_data;
   logic          fft_done = 1'b0;
   logic          disp_bank;
   logic [7:0]    frame_count;
   logic          overrun;
   logic          fft_error;

   always #5 clk = ~clk;

   fft_frame_scheduler #(
      .N_SAMPLES   (N),
      .SAMPLE_W    (W),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .fft_ready    (fft_ready),
      .fft_start    (fft_start),
      .fft_rd_addr  (fft_rd_addr),
      .fft_rd_data  (fft_rd_data),
      .fft_done     (fft_done),
      .disp_bank    (disp_bank),
      .frame_count  (frame_count),
      .overrun      (overrun),
      .fft_error    (fft_error)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned ncyc   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, ncyc);
      end
   endtask

   // Reference model: a frame is a queue of collected samples; the engine
   // side is idle (collecting), pending launch, busy, or committing.
   typedef enum {M_COLLECT, M_PENDING, M_BUSY, M_COMMITTING} mphase_t;

   mphase_t     mph = M_COLLECT;
   int unsigned capq[$];
   int unsigned frozen[N];
   bit          frozen_ok = 0;
   bit          m_start = 0, m_disp = 0, m_ovr = 0, m_err = 0, m_rd_known = 0;
   int unsigned m_fc = 0;
   int unsigned m_rd = 0;
   int unsigned waited = 0;

   task automatic freeze_frame();
      foreach (frozen[i]) frozen[i] = capq[i];
      capq.delete();
      frozen_ok = 1;
   endtask

   task automatic model_step();
      mphase_t prev;
      bit froze;
      prev  = mph;
      froze = 0;
      if (reset) begin
         mph = M_COLLECT; capq.delete(); frozen_ok = 0;
         m_start = 0; m_disp = 0; m_ovr = 0; m_err = 0; m_fc = 0;
         m_rd = 0; m_rd_known = 1;
         return;
      end
      m_rd_known = frozen_ok;
      if (frozen_ok) m_rd = frozen[fft_rd_addr] & 32'hFFFF;
      if (prev == M_COLLECT && capq.size() == N) begin
         if (sample_valid) m_ovr = 1;
         freeze_frame();
         froze = 1;
      end else if (sample_valid) begin
         if (capq.size() == N) begin
            m_ovr = 1;
         end else begin
            capq.push_back(int'(sample_data));
            if (capq.size() == N && prev == M_COLLECT) begin
               freeze_frame();
               froze = 1;
            end
         end
      end
      m_start = 0;
      case (prev)
         M_COLLECT: if (froze) mph = M_PENDING;
         M_PENDING: if (fft_ready) begin m_start = 1; mph = M_BUSY; waited = 0; end
         M_BUSY: begin
            if (fft_done) begin
               m_disp = !m_disp;
               m_fc   = (m_fc + 1) % 256;
               mph    = M_COMMITTING;
            end
`ifdef FFT_TIMEOUT_EN
            else begin
               waited++;
               if (waited == TMO) begin m_err = 1; mph = M_COLLECT; end
            end
`endif
         end
         M_COMMITTING: mph = M_COLLECT;
         default: mph = M_COLLECT;
      endcase
   endtask

   task automatic compare();
      check_eq("fft_start", fft_start, m_start);
      check_eq("disp_bank", disp_bank, m_disp);
      check_eq("frame_count", frame_count, m_fc);
      check_eq("overrun", overrun, m_ovr);
      check_eq("fft_error", fft_error, m_err);
      if (m_rd_known) check_eq("fft_rd_data", fft_rd_data, m_rd);
   endtask

   // Inputs set before tick() are sampled at edge ncyc; outputs seen after it
   // belong to cycle ncyc+1.
   task automatic tick();
      @(posedge clk);
      model_step();
      ncyc++;
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      reset = 1; sample_valid = 0; fft_done = 0; fft_ready = 0;
      tick();
      reset = 0;
   endtask

   task automatic wait_start(input int unsigned limit, output bit seen);
      seen = 0;
      for (int unsigned k = 0; k < limit && !seen; k++) begin
         tick();
         if (fft_start) seen = 1;
      end
   endtask

   task automatic send_frame(input int unsigned base);
      for (int unsigned i = 0; i < N; i++) begin
         sample_valid = 1; sample_data = W'(base + i);
         tick();
      end
      sample_valid = 0;
   endtask

   initial begin
      bit          seen;
      int unsigned last_edge, starts, dones, done_cd;

      // Reset state and first frame
      do_reset();
      check_eq("rst_start", fft_start, 0);
      check_eq("rst_disp", disp_bank, 0);
      check_eq("rst_count", frame_count, 0);
      check_eq("rst_overrun", overrun, 0);
      check_eq("rst_error", fft_error, 0);
      check_eq("rst_rd_data", fft_rd_data, 0);
      fft_ready = 1; fft_rd_addr = 5;
      send_frame(0);
      last_edge = ncyc;
      wait_start(8, seen);
      check_eq("start_seen_a", seen, 1);
      check_eq("start_latency", (ncyc + 1) - last_edge, 2);
      check_eq("rd_addr5", fft_rd_data, 5);
      fft_ready = 0;
      for (int i = 0; i < 10; i++) tick();
      check_eq("pre_commit_disp", disp_bank, 0);
      fft_done = 1;
      tick();
      fft_done = 0;
      check_eq("commit_disp", disp_bank, 1);
      check_eq("commit_count", frame_count, 1);

      // Engine not ready for 200 samples
      do_reset();
      starts = 0;
      for (int unsigned i = 0; i < 200; i++) begin
         sample_valid = 1; sample_data = W'(i);
         tick();
         if (fft_start) starts++;
      end
      sample_valid = 0;
      check_eq("no_start_unready", starts, 0);
      check_eq("overrun_set", overrun, 1);
      fft_ready = 1;
      wait_start(4, seen);
      check_eq("start_seen_b", seen, 1);
      fft_ready = 0;
      for (int unsigned a = 0; a < N; a++) begin
         fft_rd_addr = AW'(a);
         tick();
         check_eq("frozen_after_overrun", fft_rd_data, a);
      end
      fft_done = 1; tick(); fft_done = 0;
      tick(); tick();
      fft_rd_addr = 3;
      tick();
      check_eq("second_frame_rd3", fft_rd_data, 67);

`ifdef FFT_TIMEOUT_EN
      // Watchdog expiry
      do_reset();
      fft_ready = 1;
      send_frame(100);
      wait_start(8, seen);
      check_eq("start_seen_tmo", seen, 1);
      fft_ready = 0;
      for (int unsigned k = 1; k < TMO; k++) tick();
      check_eq("error_before_tmo", fft_error, 0);
      tick();
      check_eq("error_at_tmo", fft_error, 1);
      check_eq("tmo_disp", disp_bank, 0);
      check_eq("tmo_count", frame_count, 0);
      fft_ready = 1;
      send_frame(200);
      wait_start(8, seen);
      check_eq("refill_after_tmo", seen, 1);
`endif

      // Reset during WAIT_DONE, stale fft_done afterwards
      do_reset();
      fft_ready = 1;
      send_frame(7);
      wait_start(8, seen);
      check_eq("start_seen_c", seen, 1);
      tick(); tick();
      do_reset();
      fft_done = 1; tick(); fft_done = 0;
      tick();
      check_eq("rw_disp", disp_bank, 0);
      check_eq("rw_count", frame_count, 0);
      check_eq("rw_start", fft_start, 0);
      check_eq("rw_overrun", overrun, 0);
      check_eq("rw_error", fft_error, 0);

      // Randomized traffic
      do_reset();
      done_cd = 0;
      for (int unsigned c = 0; c < 12000; c++) begin
         reset        = ($urandom_range(0, 1499) == 0);
         sample_valid = ($urandom_range(0, 2) != 0);
         sample_data  = W'($urandom);
         fft_ready    = ($urandom_range(0, 3) != 0);
         fft_rd_addr  = AW'($urandom);
         fft_done     = (done_cd == 1) || ($urandom_range(0, 63) == 0);
         if (done_cd != 0) done_cd--;
         if (reset) done_cd = 0;
         tick();
         if (fft_start) done_cd = $urandom_range(1, 40);
      end
      reset = 0; fft_done = 0;

      // 256 committed frames wrap the counter and the display bank
      do_reset();
      fft_ready = 1; sample_valid = 1;
      dones = 0; done_cd = 0;
      for (int unsigned c = 0; c < 256 * 70 && dones < 256; c++) begin
         sample_data = W'($urandom);
         fft_done = 0;
         if (done_cd != 0) begin
            done_cd--;
            if (done_cd == 0) begin fft_done = 1; dones++; end
         end
         tick();
         if (fft_start) done_cd = 3;
      end
      sample_valid = 0; fft_done = 0;
      tick(); tick();
      check_eq("wrap_dones", dones, 256);
      check_eq("wrap_count", frame_count, 0);
      check_eq("wrap_disp", disp_bank, 0);
      check_eq("wrap_overrun", overrun, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
